// File: rtl/crossbar_switch_alloc_if.sv
// Control bundle between the switch allocator, the input buffers and the crossbar.
// master = allocator side, slave = input buffers / crossbar / downstream side.
interface crossbar_switch_alloc_if #(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned SEL_W   = 3
);
  logic [N_PORTS-1:0]       req_valid_i;
  logic [N_PORTS*SEL_W-1:0] req_dir_i;
  logic [N_PORTS-1:0]       req_tail_i;
  logic [N_PORTS-1:0]       out_ready_i;
  logic [N_PORTS-1:0]       pop_o;
  logic [N_PORTS*SEL_W-1:0] demux_sel_o;
  logic [N_PORTS*SEL_W-1:0] mux_sel_o;
  logic [N_PORTS-1:0]       out_valid_o;
  logic                     err_o;

  modport master (
    input  req_valid_i, req_dir_i, req_tail_i, out_ready_i,
    output pop_o, demux_sel_o, mux_sel_o, out_valid_o, err_o
  );

  modport slave (
    output req_valid_i, req_dir_i, req_tail_i, out_ready_i,
    input  pop_o, demux_sel_o, mux_sel_o, out_valid_o, err_o
  );
endinterface

// File: rtl/crossbar_switch_alloc.sv
// Wormhole switch allocator: one round-robin arbiter per output, grant held from head
// arbitration until the owning input's tail flit pops.
module crossbar_switch_alloc #(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned SEL_W   = 3
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  crossbar_switch_alloc_if.master bus
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e             r_state [N_PORTS];
  logic [SEL_W-1:0]   r_owner [N_PORTS];
  logic [SEL_W-1:0]   r_rr    [N_PORTS];

  logic [N_PORTS-1:0]       w_free;
  logic [N_PORTS-1:0]       w_req;
  logic [N_PORTS-1:0]       w_pop;
  logic [N_PORTS-1:0]       w_out_valid;
  logic [N_PORTS*SEL_W-1:0] w_mux_sel;
  logic [N_PORTS*SEL_W-1:0] w_demux_sel;
  logic                     w_err;
  logic [N_PORTS-1:0]       w_gnt_vld;
  logic [SEL_W-1:0]         w_gnt_idx [N_PORTS];

  // Lock-derived outputs and request qualification
  always_comb begin
    w_free      = '1;
    w_req       = '0;
    w_pop       = '0;
    w_out_valid = '0;
    w_mux_sel   = '0;
    w_demux_sel = '0;
    w_err       = 1'b0;
    for (int j = 0; j < N_PORTS; j++) begin
      if (r_state[j] == StLocked) begin
        w_free[r_owner[j]]                            = 1'b0;
        w_out_valid[j]                                = bus.req_valid_i[r_owner[j]];
        w_pop[r_owner[j]]                             = bus.req_valid_i[r_owner[j]] &
                                                        bus.out_ready_i[j];
        w_mux_sel[j*SEL_W +: SEL_W]                   = r_owner[j];
        w_demux_sel[int'(r_owner[j])*SEL_W +: SEL_W]  = SEL_W'(j);
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_free[i] && bus.req_valid_i[i]) begin
        if (bus.req_dir_i[i*SEL_W +: SEL_W] < SEL_W'(N_PORTS)) begin
          w_req[i] = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  // Round-robin search: scan from highest offset down so the lowest offset from rr wins
  always_comb begin
    logic [SEL_W:0]   w_sum;
    logic [SEL_W-1:0] w_cand;
    w_sum  = '0;
    w_cand = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      w_gnt_vld[j] = 1'b0;
      w_gnt_idx[j] = '0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_rr[j]} + (SEL_W+1)'(k);
        if (w_sum >= (SEL_W+1)'(N_PORTS)) begin
          w_sum = w_sum - (SEL_W+1)'(N_PORTS);
        end
        w_cand = w_sum[SEL_W-1:0];
        if (w_req[w_cand] && (bus.req_dir_i[int'(w_cand)*SEL_W +: SEL_W] == SEL_W'(j))) begin
          w_gnt_vld[j] = 1'b1;
          w_gnt_idx[j] = w_cand;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < N_PORTS; j++) begin
        r_state[j] <= StIdle;
        r_owner[j] <= '0;
        r_rr[j]    <= '0;
      end
    end else begin
      for (int j = 0; j < N_PORTS; j++) begin
        unique case (r_state[j])
          StIdle: begin
            if (w_gnt_vld[j]) begin
              r_state[j] <= StLocked;
              r_owner[j] <= w_gnt_idx[j];
              r_rr[j]    <= (w_gnt_idx[j] == SEL_W'(N_PORTS - 1)) ? '0 :
                            w_gnt_idx[j] + 1'b1;
            end
          end
          StLocked: begin
            if (w_pop[r_owner[j]] && bus.req_tail_i[r_owner[j]]) begin
              r_state[j] <= StIdle;
            end
          end
          default: r_state[j] <= StIdle;
        endcase
      end
    end
  end

  assign bus.pop_o       = w_pop;
  assign bus.out_valid_o = w_out_valid;
  assign bus.mux_sel_o   = w_mux_sel;
  assign bus.demux_sel_o = w_demux_sel;
  assign bus.err_o       = w_err;

endmodule

// File: tb/tb_crossbar_switch_alloc.sv
// Self-checking bench for crossbar_switch_alloc: directed scenarios, then randomized packet
// traffic, all compared every cycle against a packet-level reference model.
module tb_crossbar_switch_alloc;
  localparam int NP = 5;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  crossbar_switch_alloc_if #(.N_PORTS(5), .SEL_W(3)) bus ();

  crossbar_switch_alloc #(.N_PORTS(5), .SEL_W(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.master)
  );

  // Reference model: owner per output (-1 = idle) and next-priority input per output
  int m_owner [NP];
  int m_rr    [NP];
  // Packet sources: flits remaining and destination per input
  int rem [NP];
  int dir [NP];
  logic [4:0] gate, rdy;
  logic       garbage;

  logic [4:0]  e_pop, e_ov, o_pop, o_ov, o_tail;
  logic [14:0] e_mux, e_dmx, o_mux, o_dmx;
  logic        e_err, o_err;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int owned(input int i);
    for (int j = 0; j < NP; j++) if (m_owner[j] == i) return j;
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NP; j++) begin
      m_owner[j] = -1;
      m_rr[j]    = 0;
    end
  endtask

  task automatic model_expect();
    e_pop = '0; e_ov = '0; e_mux = '0; e_dmx = '0; e_err = 1'b0;
    for (int j = 0; j < NP; j++) begin
      if (m_owner[j] >= 0) begin
        int i;
        i = m_owner[j];
        e_ov[j]          = bus.req_valid_i[i];
        e_pop[i]         = bus.req_valid_i[i] & bus.out_ready_i[j];
        e_mux[3*j +: 3]  = 3'(i);
        e_dmx[3*i +: 3]  = 3'(j);
      end
    end
    for (int i = 0; i < NP; i++)
      if (owned(i) < 0 && bus.req_valid_i[i] && bus.req_dir_i[3*i +: 3] > 3'd4) e_err = 1'b1;
  endtask

  // Clock edge: tails release, idle outputs grant the requester closest after rr
  task automatic model_edge();
    int no [NP];
    for (int j = 0; j < NP; j++) no[j] = m_owner[j];
    for (int j = 0; j < NP; j++) begin
      if (m_owner[j] >= 0) begin
        if (e_pop[m_owner[j]] && bus.req_tail_i[m_owner[j]]) no[j] = -1;
      end else begin
        int best, bestd;
        best = -1; bestd = 99;
        for (int i = 0; i < NP; i++) begin
          if (owned(i) < 0 && bus.req_valid_i[i] && int'(bus.req_dir_i[3*i +: 3]) == j) begin
            int dd;
            dd = (i - m_rr[j] + NP) % NP;
            if (dd < bestd) begin
              bestd = dd;
              best  = i;
            end
          end
        end
        if (best >= 0) begin
          no[j]   = best;
          m_rr[j] = (best + 1) % NP;
        end
      end
    end
    for (int j = 0; j < NP; j++) m_owner[j] = no[j];
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      bus.req_valid_i[i] = (rem[i] > 0) && gate[i];
      bus.req_tail_i[i]  = (rem[i] == 1);
      if (garbage && owned(i) >= 0) bus.req_dir_i[3*i +: 3] = 3'($urandom_range(0, 7));
      else bus.req_dir_i[3*i +: 3] = 3'(dir[i]);
    end
    bus.out_ready_i = rdy;
  endtask

  task automatic capture();
    o_pop = bus.pop_o; o_ov = bus.out_valid_o; o_mux = bus.mux_sel_o;
    o_dmx = bus.demux_sel_o; o_err = bus.err_o; o_tail = bus.req_tail_i;
  endtask

  // Entered at posedge+1; samples at the falling edge; returns at next posedge+1
  task automatic step();
    drive();
    #4;
    model_expect();
    capture();
    check("pop", o_pop, e_pop);
    check("out_valid", o_ov, e_ov);
    check("mux_sel", o_mux, e_mux);
    check("demux_sel", o_dmx, e_dmx);
    check("err", o_err, e_err);
    @(posedge clk);
    if (rst_ni) model_edge();
    #1;
    for (int i = 0; i < NP; i++) if (e_pop[i] && rem[i] > 0) rem[i]--;
  endtask

  initial begin
    logic [4:0] t2p [7];
    logic [2:0] t2m [7];
    int k_tail, n_first, n_early, n_pops;

    model_reset();
    for (int i = 0; i < NP; i++) begin
      rem[i] = 0;
      dir[i] = 0;
    end
    gate = '1; rdy = '1; garbage = 1'b1;
    bus.req_valid_i = '0; bus.req_dir_i = '0; bus.req_tail_i = '0; bus.out_ready_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_ni = 1'b1;
    step();

    // W -> E, 3 flits
    rem[2] = 3; dir[2] = 3;
    step();
    check("t1_no_pop_in_t", o_pop, 5'b00000);
    step();
    check("t1_mux_E", o_mux[11:9], 3'b010);
    check("t1_demux_W", o_dmx[8:6], 3'b011);
    check("t1_pop_W", o_pop, 5'b00100);
    step();
    step();
    check("t1_tail_pop", o_pop & o_tail, 5'b00100);
    step();
    check("t1_E_idle", o_mux[11:9], 3'b000);
    check("t1_E_novalid", o_ov, 5'b00000);

    // N, S, L contend for L with single-flit packets
    t2p = '{5'b00000, 5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b10000, 5'b00000};
    t2m = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b100, 3'b000};
    rem[0] = 1; rem[1] = 1; rem[4] = 1;
    dir[0] = 4; dir[1] = 4; dir[4] = 4;
    for (int c = 0; c < 7; c++) begin
      step();
      check($sformatf("t2_pop_c%0d", c), o_pop, t2p[c]);
      if (o_pop != 5'b00000) check($sformatf("t2_muxL_c%0d", c), o_mux[14:12], t2m[c]);
    end

    // N waits behind W's packet on E
    rem[2] = 3; dir[2] = 3;
    step();
    rem[0] = 2; dir[0] = 3;
    k_tail = -1; n_first = -1; n_early = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (o_pop[2] && o_tail[2]) k_tail = c;
      if (o_pop[0] && n_first < 0) n_first = c;
      if (o_pop[0] && k_tail < 0) n_early++;
    end
    check("t3_N_blocked", 15'(n_early), 15'd0);
    check("t3_gap", 15'(n_first - k_tail), 15'd2);

    // S -> L stalled by out_ready
    rem[1] = 4; dir[1] = 4;
    step();
    rdy = 5'b01111;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t4_stall_pop", o_pop, 5'b00000);
      check("t4_stall_ov", o_ov, 5'b10000);
      check("t4_stall_mux", o_mux[14:12], 3'b001);
    end
    rdy = '1;
    n_pops = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (o_pop[1]) n_pops++;
    end
    check("t4_resume_pops", 15'(n_pops), 15'd4);

    // Five independent pairs in parallel
    dir[0] = 1; dir[1] = 0; dir[2] = 3; dir[3] = 2; dir[4] = 4;
    for (int i = 0; i < NP; i++) rem[i] = 2;
    step();
    step();
    check("t5_all_pop", o_pop, 5'b11111);
    check("t5_all_valid", o_ov, 5'b11111);
    step();
    step();

    // Invalid direction
    rem[4] = 1; dir[4] = 6;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6_err", o_err, 1'b1);
      check("t6_no_pop", o_pop, 5'b00000);
    end
    rem[4] = 0;
    step();
    check("t6_err_clear", o_err, 1'b0);

    // Reset mid-packet N -> W
    rem[0] = 4; dir[0] = 2;
    step();
    step();
    drive();
    #2;
    rst_ni = 1'b0;
    #1;
    capture();
    check("rst_mux", o_mux, 15'd0);
    check("rst_demux", o_dmx, 15'd0);
    check("rst_pop", o_pop, 5'b00000);
    check("rst_ov", o_ov, 5'b00000);
    model_reset();
    for (int i = 0; i < NP; i++) rem[i] = 0;
    @(posedge clk);
    #1;
    step();
    rst_ni = 1'b1;
    rem[0] = 1; dir[0] = 2; rem[1] = 1; dir[1] = 2;
    step();
    step();
    check("rst_rr_pop", o_pop, 5'b00001);
    check("rst_rr_muxW", o_mux[8:6], 3'b000);
    step();
    step();

    // Randomized packet traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
          int r;
          r = $urandom_range(0, 15);
          dir[i] = (r < 14) ? r % 5 : 5 + (r % 3);
          rem[i] = $urandom_range(1, 4);
        end
        gate[i] = ($urandom_range(0, 3) != 0);
        rdy[i]  = ($urandom_range(0, 3) != 0);
      end
      step();
      for (int i = 0; i < NP; i++)
        if (dir[i] > 4 && rem[i] > 0 && $urandom_range(0, 1) == 0) rem[i] = 0;
    end

    gate = '1; rdy = '1;
    for (int i = 0; i < NP; i++) if (dir[i] > 4) rem[i] = 0;
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/crossbar_switch_alloc.md
# crossbar_switch_alloc

Wormhole switch allocator for the 5-port NoC router. It arbitrates head-flit requests from the N/S/W/E/L input buffers for output ports using one round-robin arbiter per output. It holds each grant until the packet's tail flit transfers, and drives the demux and mux select lines of `crossbar_switch_inner`. It sits between the input FIFOs and the crossbar, and is the control end of the crossbar interface.

## Interface
Parameters:
- `N_PORTS`, 5: port count. Fixed; index order N=0, S=1, W=2, E=3, L=4.
- `SEL_W`, 3: select width. Encoding N=000, S=001, W=010, E=011, L=100.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  router clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  5  input buffer i has a flit at its head
- `req_dir_i`  in  15  destination output of input i's head flit, bits [3i+2:3i]
- `req_tail_i`  in  5  flit at input i is a tail flit; single-flit packets have tail set on the head
- `out_ready_i`  in  5  downstream of output j can accept a flit
- `pop_o`  out  5  flit at input i transfers this cycle; input buffer dequeues
- `demux_sel_o`  out  15  output selected for input i; drives `*_cs_sel_demux_i`
- `mux_sel_o`  out  15  input selected for output j; drives `*_cs_sel_mux_i`
- `out_valid_o`  out  5  output j carries a valid flit this cycle
- `err_o`  out  1  one-cycle pulse: an unlocked input presented `req_dir` of 101–111

## Operation
- Per-output state: `IDLE` or `LOCKED`, plus a 3-bit `owner` and a 3-bit round-robin pointer `rr`.
- Input i is *free* when it owns no output. Only free inputs with `req_valid_i[i]`=1 issue requests, to output `req_dir_i[i]`.
- `req_dir` of an input that owns a lock is ignored; body flits carry payload.
- Invalid `req_dir` (101–111): the request is never granted, `pop` stays 0, and `err_o` pulses every cycle the condition holds.
- `IDLE` output j: the requester with the highest priority wins. Priority starts at index `rr`, ascending mod 5. On the next edge, j moves to `LOCKED` with `owner` = winner, and `rr` = winner+1 mod 5.
- An input can win at most one output; its single `req_dir` guarantees this.
- `LOCKED` output j with `owner` = i:
  - `out_valid_o[j]` = `req_valid_i[i]`
  - `pop_o[i]` = `req_valid_i[i]` & `out_ready_i[j]`
  - `mux_sel_o[j]` = i
  - `demux_sel_o[i]` = j
- Pop with `req_tail_i[i]`=1 returns j to `IDLE` on that edge.
- Unlocked outputs and free inputs drive select 000, with `out_valid`/`pop` at 0. Consumers qualify selects with valid.
- A request for a `LOCKED` output waits with `pop`=0. No preemption.

## Timing
- Reset (async assert, sync release): all outputs `IDLE`, all `rr` = 0 (N), and all outputs 0: `pop_o`, `out_valid_o`, `mux_sel_o`, `demux_sel_o`, `err_o`.
- `mux_sel_o` and `demux_sel_o` depend only on registered lock state.
- `pop_o` and `out_valid_o` are combinational from lock state, `req_valid_i` and `out_ready_i`.
- `err_o` is combinational.
- Arbitration latency: a head request in cycle t (output `IDLE`) gives selects valid and first possible pop in t+1.
- Release: tail popped in cycle k gives `IDLE` in k+1, re-arbitration in k+1, and the new owner's first pop in k+2. There is a one-cycle bubble per packet per output.
- Single-flit packet: locked for exactly one cycle if `out_ready`=1.
- `out_ready`=0 while locked: lock held, `pop`=0, `out_valid` follows `req_valid`.
- `req_valid`=0 mid-packet: lock held, no transfer.
- Simultaneous requests from up to 5 inputs to one output are resolved by `rr` within one cycle. Independent outputs allocate in parallel in the same cycle.
- Reset asserted mid-packet: all locks drop immediately. Partially sent packets are the upstream's responsibility.

## Test plan
- After reset, W (2) requests E (`req_dir`=011), 3-flit packet, `out_ready`=1 → cycle t+1: `mux_sel` E=010, `demux_sel` W=011; `pop[2]`=1 for 3 cycles; E `IDLE` after tail; `rr_E`=3.
- N, S and L all request L (100) in the same cycle, single-flit packets, `rr_L`=0 → grant order N, S, L. Pops in cycles t+1, t+3, t+5; `mux_sel` L = 000, 001, 100.
- W→E locked. N requests E → `pop[0]`=0 until W's tail pops in cycle k; N's first pop is in k+2.
- Locked S→L with `out_ready[4]`=0 for 4 cycles → `pop[1]`=0 and `out_valid[4]`=1 throughout; selects stable; transfer resumes when ready returns to 1.
- Parallel: N→S, S→N, W→E, E→W, L→L requested in one cycle → all 5 locked in t+1; all 5 `pop` bits 1 simultaneously.
- L requests `req_dir`=110 → `err_o`=1 each cycle, no grant. Reset mid 4-flit packet N→W → all selects 000 and `pop`=0 immediately; `rr` = 0 after release.
